// File: rtl/mcyc_ctrl_pkg.sv
// mcyc_ctrl_pkg: shared types for the multi-cycle MIPS-subset control FSM.
// Holds the state enum, opcode/funct constants, the datapath select encodings,
// the control-word struct and the DECODE-state dispatch function.
package mcyc_ctrl_pkg;

    typedef enum logic [4:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB,
        EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, ILLEGAL, BUS_ERR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_RTYPE = 3'b010, ALU_SLT = 3'b011} alu_op_t;
    typedef enum logic [1:0] {PCS_ALU, PCS_ALUOUT, PCS_JUMP, PCS_RS} pc_src_t;
    typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} src_b_t;
    typedef enum logic [1:0] {RD_RT, RD_RD, RD_R31} reg_dst_t;
    typedef enum logic [1:0] {M2R_ALUOUT, M2R_MDR, M2R_PC} mem_to_reg_t;

    typedef struct packed {
        logic        pc_write;
        logic        pc_write_cond;
        logic        branch_ne;
        pc_src_t     pc_source;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        logic        ir_write;
        reg_dst_t    reg_dst;
        mem_to_reg_t mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
        logic        retired;
        logic        illegal;
        logic        bus_err;
    } ctrl_t;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:        return (fn == FN_JR) ? JR : EXEC_R;
            OP_LW, OP_SW:    return MEM_ADDR;
            OP_ADDI, OP_SLTI: return EXEC_I;
            OP_BEQ, OP_BNE:  return BRANCH;
            OP_J:            return JUMP;
            OP_JAL:          return JAL;
            default:         return ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: bundle between the control FSM and the datapath.
// master (controller): takes run/opcode/funct/mem_ready, drives all selects,
// enables, ALU-op and the retired/illegal/bus_err status pulses.
// slave (datapath): the mirror view.
interface multicycle_ctrl_fsm_if;
    logic       run_i;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       pc_write_cond_o;
    logic       branch_ne_o;
    logic [1:0] pc_source_o;
    logic       iord_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic [1:0] reg_dst_o;
    logic [1:0] mem_to_reg_o;
    logic       reg_write_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_op_o;
    logic       retired_o;
    logic       illegal_o;
    logic       bus_err_o;

    modport master (
        input  run_i, opcode_i, funct_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o, iord_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, retired_o,
               illegal_o, bus_err_o
    );

    modport slave (
        output run_i, opcode_i, funct_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, branch_ne_o, pc_source_o, iord_o,
               mem_read_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o,
               reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, retired_o,
               illegal_o, bus_err_o
    );
endinterface

// File: rtl/mcyc_ctrl_decode.sv
// mcyc_ctrl_decode: combinational state -> control-word decode.
// Ports: state_i (current FSM state), opcode_i (IR opcode, picks ADD/SLT and
// beq/bne), mem_ready_i (gates the fetch loads and the sw retire), ctrl_o.
module mcyc_ctrl_decode
    import mcyc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                // IR and PC+4 are only committed once the read data is valid
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
            MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.mem_to_reg = M2R_MDR;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.retired    = 1'b1;
            end
            MEM_WR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.retired   = mem_ready_i;
            end
            EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_RTYPE;
            end
            R_WB: begin
                ctrl_o.reg_dst   = RD_RD;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.retired   = 1'b1;
            end
            EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            I_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.retired   = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCS_ALUOUT;
                ctrl_o.branch_ne     = (opcode_i == OP_BNE);
                ctrl_o.retired       = 1'b1;
            end
            JUMP: begin
                ctrl_o.pc_source = PCS_JUMP;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.retired   = 1'b1;
            end
            JAL: begin
                // link value is the current PC, already advanced to PC+4 in FETCH
                ctrl_o.pc_source  = PCS_JUMP;
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.reg_dst    = RD_R31;
                ctrl_o.mem_to_reg = M2R_PC;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.retired    = 1'b1;
            end
            JR: begin
                ctrl_o.pc_source = PCS_RS;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.retired   = 1'b1;
            end
            ILLEGAL: ctrl_o.illegal = 1'b1;
            BUS_ERR: ctrl_o.bus_err = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: Moore control FSM for the multi-cycle MIPS-subset datapath.
// Ports: clk_i (rising-edge clock), rst_i (async active-high reset),
// bus (master view of multicycle_ctrl_fsm_if: run/opcode/funct/mem_ready in,
// datapath controls and status pulses out). TIMEOUT: memory wait limit (2..255).
module multicycle_ctrl_fsm
    import mcyc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multicycle_ctrl_fsm_if.master bus
);
    state_t     state_q, state_d, done_st, wait_st;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout;
    ctrl_t      c;

    assign timeout = (cnt_q == 8'(TIMEOUT - 1));
    assign done_st = bus.run_i ? FETCH : IDLE;
    // memory states: ready wins, otherwise abort once the budget is spent
    assign wait_st = timeout ? BUS_ERR : state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = bus.run_i ? FETCH : IDLE;
            FETCH:    state_d = bus.mem_ready_i ? DECODE : wait_st;
            DECODE:   state_d = decode_next(bus.opcode_i, bus.funct_i);
            MEM_ADDR: state_d = (bus.opcode_i == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = bus.mem_ready_i ? MEM_WB : wait_st;
            MEM_WR:   state_d = bus.mem_ready_i ? done_st : wait_st;
            EXEC_R:   state_d = R_WB;
            EXEC_I:   state_d = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: state_d = done_st;
            default:  state_d = IDLE;
        endcase
    end

    // counts only while parked in a memory state; any state change clears it
    always_comb begin
        cnt_d = '0;
        if (state_q inside {FETCH, MEM_RD, MEM_WR} && state_d == state_q)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mcyc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (bus.opcode_i),
        .mem_ready_i (bus.mem_ready_i),
        .ctrl_o      (c)
    );

    assign bus.pc_write_o      = c.pc_write;
    assign bus.pc_write_cond_o = c.pc_write_cond;
    assign bus.branch_ne_o     = c.branch_ne;
    assign bus.pc_source_o     = c.pc_source;
    assign bus.iord_o          = c.iord;
    assign bus.mem_read_o      = c.mem_read;
    assign bus.mem_write_o     = c.mem_write;
    assign bus.ir_write_o      = c.ir_write;
    assign bus.reg_dst_o       = c.reg_dst;
    assign bus.mem_to_reg_o    = c.mem_to_reg;
    assign bus.reg_write_o     = c.reg_write;
    assign bus.alu_src_a_o     = c.alu_src_a;
    assign bus.alu_src_b_o     = c.alu_src_b;
    assign bus.alu_op_o        = c.alu_op;
    assign bus.retired_o       = c.retired;
    assign bus.illegal_o       = c.illegal;
    assign bus.bus_err_o       = c.bus_err;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: scoreboard bench for the multi-cycle control FSM.
module tb_multicycle_ctrl_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if ifc ();
    multicycle_ctrl_fsm #(.TIMEOUT(16)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc));

    // {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, retired, illegal, bus_err}
    logic [22:0] obs;
    assign obs = {ifc.pc_write_o, ifc.pc_write_cond_o, ifc.branch_ne_o, ifc.pc_source_o,
                  ifc.iord_o, ifc.mem_read_o, ifc.mem_write_o, ifc.ir_write_o,
                  ifc.reg_dst_o, ifc.mem_to_reg_o, ifc.reg_write_o, ifc.alu_src_a_o,
                  ifc.alu_src_b_o, ifc.alu_op_o, ifc.retired_o, ifc.illegal_o, ifc.bus_err_o};

    typedef struct {
        logic        run;
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [22:0] v;
        string       nm;
    } ent_t;
    ent_t sb_q[$];

    logic [22:0] p_idle, p_fw, p_fr, p_dec, p_maddr, p_mrd, p_mwb, p_mww, p_mwr, p_exr, p_rwb;
    logic [22:0] p_exs, p_iwb, p_bne, p_beq, p_j, p_jal, p_jr, p_ill, p_berr;

    function automatic logic [22:0] mk(input int pcw, pcwc, bne, pcs, iord, mr, mw, irw,
                                       rdst, m2r, rw, sa, sb, aop, ret, ill, berr);
        return {1'(pcw), 1'(pcwc), 1'(bne), 2'(pcs), 1'(iord), 1'(mr), 1'(mw), 1'(irw),
                2'(rdst), 2'(m2r), 1'(rw), 1'(sa), 2'(sb), 3'(aop), 1'(ret), 1'(ill), 1'(berr)};
    endfunction

    task automatic push(input logic run, input logic rdy, input logic [5:0] op,
                        input logic [5:0] fn, input logic [22:0] v, input string nm);
        ent_t e;
        e.run = run; e.rdy = rdy; e.op = op; e.fn = fn; e.v = v; e.nm = nm;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #3;
        n_chk++;
        if (obs !== 23'd0) begin n_fail++; $display("FAIL reset_outputs: got %06h expected 000000", obs); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        ent_t e;
        push(1, 0, 6'h2B, 0, p_idle, "sw_idle");
        push(1, 1, 6'h2B, 0, p_fr, "sw_fetch");
        push(1, 0, 6'h2B, 0, p_dec, "sw_decode");
        push(1, 0, 6'h2B, 0, p_maddr, "sw_mem_addr");
        push(1, 0, 6'h2B, 0, p_mww, "sw_mem_wr_wait");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            @(posedge clk); #1;
        end
        ifc.mem_ready_i = 1'b0;
        #2;
        n_chk++;
        if (ifc.mem_write_o !== 1'b1) begin n_fail++; $display("FAIL mem_write_before_reset: got %b expected 1", ifc.mem_write_o); end
        rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== 23'd0) begin n_fail++; $display("FAIL async_reset: got %06h expected 000000", obs); end
        @(posedge clk); #3;
        n_chk++;
        if (obs !== 23'd0) begin n_fail++; $display("FAIL after_reset_edge: got %06h expected 000000", obs); end
        @(posedge clk); #1;
        rst = 1'b0;
        push(1, 0, 6'h3F, 0, p_idle, "rel_idle");
        push(1, 0, 6'h3F, 0, p_fw, "rel_fetch_wait");
        push(1, 1, 6'h3F, 0, p_fr, "rel_fetch_ready");
        push(0, 0, 6'h3F, 0, p_dec, "rel_decode");
        push(0, 0, 6'h3F, 0, p_ill, "rel_illegal");
        push(0, 0, 6'h3F, 0, p_idle, "rel_back_idle");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        ent_t e;
        int rets = 0;
        push(1, 0, 6'h00, 6'h20, p_idle, "add_idle");
        push(1, 1, 6'h00, 6'h20, p_fr, "add_fetch");
        push(0, 0, 6'h00, 6'h20, p_dec, "add_decode");
        push(0, 0, 6'h00, 6'h20, p_exr, "add_exec_r");
        push(0, 0, 6'h00, 6'h20, p_rwb, "add_r_wb");
        push(0, 0, 6'h00, 6'h20, p_idle, "add_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 1) begin n_fail++; $display("FAIL add_retire_count: got %0d expected 1", rets); end
    endtask

    task automatic test_lw();
        ent_t e;
        int rets = 0;
        push(1, 0, 6'h23, 0, p_idle, "lw_idle");
        push(1, 1, 6'h23, 0, p_fr, "lw_fetch");
        push(1, 0, 6'h23, 0, p_dec, "lw_decode");
        push(1, 0, 6'h23, 0, p_maddr, "lw_mem_addr");
        for (int i = 0; i < 3; i++) push(1, 0, 6'h23, 0, p_mrd, "lw_mem_rd_wait");
        push(1, 1, 6'h23, 0, p_mrd, "lw_mem_rd_ready");
        push(0, 0, 6'h23, 0, p_mwb, "lw_mem_wb");
        push(0, 0, 6'h23, 0, p_idle, "lw_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 1) begin n_fail++; $display("FAIL lw_retire_count: got %0d expected 1", rets); end
    endtask

    task automatic test_jumps();
        ent_t e;
        int rets = 0;
        push(1, 0, 6'h03, 0, p_idle, "jal_idle");
        push(1, 1, 6'h03, 0, p_fr, "jal_fetch");
        push(0, 0, 6'h03, 0, p_dec, "jal_decode");
        push(0, 0, 6'h03, 0, p_jal, "jal_exec");
        push(1, 0, 6'h00, 6'h08, p_idle, "jr_idle");
        push(1, 1, 6'h00, 6'h08, p_fr, "jr_fetch");
        push(0, 0, 6'h00, 6'h08, p_dec, "jr_decode");
        push(0, 0, 6'h00, 6'h08, p_jr, "jr_exec");
        push(0, 0, 6'h00, 6'h08, p_idle, "jr_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 2) begin n_fail++; $display("FAIL jump_retire_count: got %0d expected 2", rets); end
    endtask

    task automatic test_branch();
        ent_t e;
        int rets = 0;
        push(1, 0, 6'h05, 0, p_idle, "bne_idle");
        push(1, 1, 6'h05, 0, p_fr, "bne_fetch");
        push(1, 0, 6'h05, 0, p_dec, "bne_decode");
        push(1, 0, 6'h05, 0, p_bne, "bne_branch");
        push(1, 1, 6'h04, 0, p_fr, "beq_fetch");
        push(1, 0, 6'h04, 0, p_dec, "beq_decode");
        push(0, 0, 6'h04, 0, p_beq, "beq_branch");
        push(0, 0, 6'h04, 0, p_idle, "beq_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 2) begin n_fail++; $display("FAIL branch_retire_count: got %0d expected 2", rets); end
    endtask

    task automatic test_timeout_illegal();
        ent_t e;
        int rets = 0;
        int errs = 0;
        push(1, 0, 6'h3F, 0, p_idle, "to_idle");
        for (int i = 0; i < 16; i++) push(0, 0, 6'h3F, 0, p_fw, "to_fetch_wait");
        push(0, 0, 6'h3F, 0, p_berr, "to_bus_err");
        push(0, 0, 6'h3F, 0, p_idle, "to_idle_after");
        push(1, 0, 6'h3F, 0, p_idle, "late_idle");
        for (int i = 0; i < 15; i++) push(0, 0, 6'h3F, 0, p_fw, "late_fetch_wait");
        push(0, 1, 6'h3F, 0, p_fr, "late_ready_wins");
        push(0, 0, 6'h3F, 0, p_dec, "ill_decode");
        push(0, 0, 6'h3F, 0, p_ill, "ill_pulse");
        push(0, 0, 6'h3F, 0, p_idle, "ill_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            errs += int'(ifc.bus_err_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 0) begin n_fail++; $display("FAIL timeout_retire_count: got %0d expected 0", rets); end
        n_chk++;
        if (errs != 1) begin n_fail++; $display("FAIL bus_err_count: got %0d expected 1", errs); end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int rets = 0;
        push(1, 0, 6'h2B, 0, p_idle, "b2b_idle");
        push(1, 1, 6'h2B, 0, p_fr, "b2b_sw_fetch");
        push(0, 0, 6'h2B, 0, p_dec, "b2b_sw_decode");
        push(0, 0, 6'h2B, 0, p_maddr, "b2b_sw_addr");
        push(0, 0, 6'h2B, 0, p_mww, "b2b_sw_wait");
        push(1, 1, 6'h2B, 0, p_mwr, "b2b_sw_done");
        push(1, 1, 6'h08, 0, p_fr, "b2b_addi_fetch");
        push(1, 0, 6'h08, 0, p_dec, "b2b_addi_decode");
        push(1, 0, 6'h08, 0, p_maddr, "b2b_addi_exec");
        push(1, 0, 6'h08, 0, p_iwb, "b2b_addi_wb");
        push(1, 1, 6'h0A, 0, p_fr, "b2b_slti_fetch");
        push(1, 0, 6'h0A, 0, p_dec, "b2b_slti_decode");
        push(1, 0, 6'h0A, 0, p_exs, "b2b_slti_exec");
        push(1, 0, 6'h0A, 0, p_iwb, "b2b_slti_wb");
        push(1, 1, 6'h02, 0, p_fr, "b2b_j_fetch");
        push(1, 0, 6'h02, 0, p_dec, "b2b_j_decode");
        push(0, 0, 6'h02, 0, p_j, "b2b_j_exec");
        push(0, 0, 6'h02, 0, p_idle, "b2b_idle_after");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ifc.run_i = e.run; ifc.mem_ready_i = e.rdy; ifc.opcode_i = e.op; ifc.funct_i = e.fn;
            #2;
            n_chk++;
            if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %06h expected %06h", e.nm, obs, e.v); end
            rets += int'(ifc.retired_o);
            @(posedge clk); #1;
        end
        n_chk++;
        if (rets != 4) begin n_fail++; $display("FAIL b2b_retire_count: got %0d expected 4", rets); end
    endtask

    initial begin
        ifc.run_i = 1'b0; ifc.mem_ready_i = 1'b0; ifc.opcode_i = '0; ifc.funct_i = '0;
        //          pcw pcwc bne pcs iord mr mw irw rdst m2r rw sa sb aop ret ill berr
        p_idle  = '0;
        p_fw    = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        p_fr    = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        p_dec   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        p_maddr = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        p_mrd   = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p_mwb   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
        p_mww   = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        p_mwr   = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        p_exr   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
        p_rwb   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
        p_exs   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0);
        p_iwb   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        p_bne   = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        p_beq   = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        p_j     = mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        p_jal   = mk(1, 0, 0, 2, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 1, 0, 0);
        p_jr    = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        p_ill   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        p_berr  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_reset_mid_write();
        test_rtype();
        test_lw();
        test_jumps();
        test_branch();
        test_timeout_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Moore-style control FSM that sequences a multi-cycle version of the team's MIPS-subset datapath. In that datapath, one shared instruction/data memory sits behind IorD, and the IR, A, B, MDR and ALUOut registers sit between stages. It decodes the opcode and funct held in IR and drives every mux select, write enable and ALU-op for each phase. Memory phases wait on a ready handshake and are guarded by a timeout.

Parameters:
TIMEOUT, 16, max cycles any memory state waits for mem_ready_i before aborting; legal range 2..255.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
run_i  in  1  start/continue execution; sampled in IDLE and at each instruction end
opcode_i  in  6  IR[31:26]
funct_i  in  6  IR[5:0]
mem_ready_i  in  1  memory completes the current read/write this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition true
branch_ne_o  out  1  branch condition is !zero (bne); else zero (beq)
pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump address, 11 A (rs)
iord_o  out  1  0 memory address = PC, 1 = ALUOut
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  IR load enable
reg_dst_o  out  2  00 rt, 01 rd, 10 r31
mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC
reg_write_o  out  1  register-file write enable
alu_src_a_o  out  1  0 PC, 1 A
alu_src_b_o  out  2  00 B, 01 const 4, 10 sign-ext, 11 sign-ext<<2
alu_op_o  out  3  000 ADD, 001 SUB, 010 R-type (use funct), 011 SLT
retired_o  out  1  one-cycle pulse when an instruction completes
illegal_o  out  1  one-cycle pulse on an unsupported opcode/funct
bus_err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset: state=IDLE, timeout counter=0. All outputs are 0 during and after reset until IDLE is left. Reset asserted in any state aborts immediately; no write enable may be high in the following cycle.
- Outputs are a pure function of state, plus mem_ready_i gating in memory states. All selects not listed for a state are 0.
- IDLE: all outputs 0. run_i=1 -> FETCH.
- FETCH: mem_read, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready_i=1. Stay while mem_ready_i=0. On ready -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct 0x08 -> JR
  - 0x00 with any other funct -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08 or 0x0A -> EXEC_I
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - any other -> ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: iord=1, mem_read; wait for ready -> MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write.
- MEM_WR: iord=1, mem_write held until ready; instruction ends on ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB.
- R_WB: reg_dst=01, mem_to_reg=00, reg_write.
- EXEC_I: alu_src_a=1, alu_src_b=10, ADD for 0x08 or SLT for 0x0A -> I_WB.
- I_WB: reg_dst=00, mem_to_reg=00, reg_write.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond, pc_source=01, branch_ne=(opcode==0x05).
- JUMP: pc_source=10, pc_write.
- JAL: pc_source=10, pc_write, reg_dst=10, mem_to_reg=10, reg_write. The register file captures the pre-edge PC, which is already PC+4.
- JR: pc_source=11, pc_write.
- Instruction end: MEM_WB, MEM_WR+ready, R_WB, I_WB, BRANCH, JUMP, JAL and JR each pulse retired_o. Next state is FETCH if run_i=1, else IDLE. run_i falling mid-instruction never truncates the instruction.
- ILLEGAL: illegal_o=1 for one cycle, no retire, -> IDLE.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each waiting cycle.
  - If mem_ready_i is still 0 when the counter reaches TIMEOUT-1, the next state is BUS_ERR instead of continuing to wait.
  - Ready arriving in that same cycle wins.
  - BUS_ERR: bus_err_o=1 for one cycle, all write enables 0, -> IDLE.

Decomposition:
- Package mcyc_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, JAL, JR, ILLEGAL, BUS_ERR)
  - opcode/funct constants
  - ALU-op, pc_source, alu_src_b, reg_dst and mem_to_reg encodings
- One sub-module, mcyc_ctrl_decode: combinational state -> output-vector decode, instantiated by the FSM. The timeout counter stays in the top.

Test Plan:
- Reset mid-MEM_WR with mem_write high -> all outputs 0 in the cycle after the reset edge, state IDLE; after release, run_i=1 -> FETCH with mem_read=1, iord=0.
- add (op 0, funct 0x20), ready on the first cycle -> FETCH, DECODE, EXEC_R (alu_op 010), R_WB (reg_dst 01, reg_write) = 4 cycles, one retired_o pulse.
- lw (0x23) with mem_ready_i delayed 3 cycles in MEM_RD -> 4 MEM_RD cycles, then MEM_WB with mem_to_reg 01, reg_dst 00; total 8 cycles.
- jal (0x03) -> JAL state: pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1; jr (funct 0x08) -> pc_source=11, no reg_write.
- bne (0x05) -> BRANCH with pc_write_cond=1, branch_ne=1, alu_op 001; beq (0x04) gives branch_ne=0.
- mem_ready_i held 0 in FETCH with TIMEOUT=16 -> bus_err_o pulses after 16 FETCH cycles, then IDLE. Opcode 0x3F -> illegal_o pulse, IDLE, no retired_o.
